// File: rtl/instr_dispatch_if.sv
// Issue-side bus between the upstream instruction source, the dispatcher and the three-lane core.
// The master drives instructions, enable and done; the slave (dispatcher) drives everything else.
interface instr_dispatch_if #(
    parameter int IW = 28
);
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_instr;
    logic [1:0]    in_lane;
    logic          enable;
    logic          done;
    logic [IW-1:0] inst1;
    logic [IW-1:0] inst2;
    logic [IW-1:0] inst3;
    logic          start1;
    logic          start2;
    logic          start3;
    logic          busy;
    logic [15:0]   issued_cnt;
    logic          timeout_err;
    logic          bad_lane;

    modport master (
        output in_valid, in_instr, in_lane, enable, done,
        input  in_ready, inst1, inst2, inst3, start1, start2, start3,
               busy, issued_cnt, timeout_err, bad_lane
    );

    modport slave (
        input  in_valid, in_instr, in_lane, enable, done,
        output in_ready, inst1, inst2, inst3, start1, start2, start3,
               busy, issued_cnt, timeout_err, bad_lane
    );
endinterface

// File: rtl/instr_dispatch.sv
// Three-lane instruction dispatcher: per-lane FIFOs feed one bundle at a time to the core,
// then wait for done or give up after TIMEOUT wait cycles.
//
// state   | meaning
// S_IDLE  | no bundle outstanding; issues when enabled and any lane has work
// S_ISSUE | start strobes high for exactly this cycle
// S_WAIT  | bundle running on the core; waits for done or timeout
module instr_dispatch #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255,
    parameter int IW      = 28
) (
    input logic             clk,
    input logic             rst_n,
    instr_dispatch_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    logic [IW-1:0] mem_q [3][DEPTH];
    logic [AW:0]   wptr_q [3];
    logic [AW:0]   rptr_q [3];
    logic [2:0]    empty;
    logic [2:0]    full;
    logic [2:0]    push;
    logic [2:0]    pop;
    logic          in_ready;

    state_t        state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          terr_q, terr_d;
    logic          bad_q, bad_d;
    logic          busy_q, busy_d;
    logic [2:0]    mask_q, mask_d;
    logic [2:0]    start_q, start_d;
    logic [IW-1:0] inst_q [3];
    logic [IW-1:0] inst_d [3];

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            empty[k] = (wptr_q[k] == rptr_q[k]);
            full[k]  = ((wptr_q[k] - rptr_q[k]) == (AW+1)'(DEPTH));
        end
    end

    // Readiness looks only at pre-pop occupancy, so a full lane stays stalled on its pop cycle.
    always_comb begin
        case (bus.in_lane)
            2'd1:    in_ready = !full[0];
            2'd2:    in_ready = !full[1];
            2'd3:    in_ready = !full[2];
            default: in_ready = 1'b1;
        endcase
    end

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            push[k] = bus.in_valid && in_ready && (bus.in_lane == 2'(k + 1));
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (push[k]) begin
                mem_q[k][wptr_q[k][AW-1:0]] <= bus.in_instr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                wptr_q[k] <= '0;
                rptr_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (push[k]) wptr_q[k] <= wptr_q[k] + 1'b1;
                if (pop[k])  rptr_q[k] <= rptr_q[k] + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        cnt_d   = cnt_q;
        terr_d  = terr_q;
        mask_d  = mask_q;
        inst_d  = inst_q;
        start_d = '0;
        pop     = '0;
        bad_d   = bad_q | (bus.in_valid && (bus.in_lane == 2'd0));

        case (state_q)
            S_IDLE: begin
                if (bus.enable && (empty != 3'b111)) begin
                    state_d = S_ISSUE;
                    pop     = ~empty;
                    start_d = ~empty;
                    mask_d  = ~empty;
                    tmo_d   = '0;
                    for (int k = 0; k < 3; k++) begin
                        if (!empty[k]) inst_d[k] = mem_q[k][rptr_q[k][AW-1:0]];
                    end
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                // done takes priority over an expiring timer on the same cycle
                if (bus.done) begin
                    state_d = S_IDLE;
                    tmo_d   = '0;
                    cnt_d   = cnt_q + 16'(mask_q[0]) + 16'(mask_q[1]) + 16'(mask_q[2]);
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    state_d = S_IDLE;
                    tmo_d   = '0;
                    terr_d  = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tmo_q   <= '0;
            cnt_q   <= '0;
            terr_q  <= 1'b0;
            bad_q   <= 1'b0;
            busy_q  <= 1'b0;
            mask_q  <= '0;
            start_q <= '0;
            for (int k = 0; k < 3; k++) inst_q[k] <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
            bad_q   <= bad_d;
            busy_q  <= busy_d;
            mask_q  <= mask_d;
            start_q <= start_d;
            for (int k = 0; k < 3; k++) inst_q[k] <= inst_d[k];
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.inst1       = inst_q[0];
    assign bus.inst2       = inst_q[1];
    assign bus.inst3       = inst_q[2];
    assign bus.start1      = start_q[0];
    assign bus.start2      = start_q[1];
    assign bus.start3      = start_q[2];
    assign bus.busy        = busy_q;
    assign bus.issued_cnt  = cnt_q;
    assign bus.timeout_err = terr_q;
    assign bus.bad_lane    = bad_q;
endmodule

// File: tb/tb_instr_dispatch.sv
// Bench for instr_dispatch: directed scenarios plus random traffic, checked every cycle
// against a queue-based model of the dispatcher's externally visible behaviour.
module tb_instr_dispatch;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;
    localparam int IW      = 28;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_err    = 0;

    instr_dispatch_if #(.IW(IW)) bus ();

    instr_dispatch #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .IW(IW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: queues per lane, bundle age (-1 idle, 0 start cycle, n = n-th wait cycle).
    logic [IW-1:0] mq [3][$];
    logic [IW-1:0] m_inst [3] = '{default: '0};
    logic [2:0]    m_start = '0;
    logic [15:0]   m_cnt = '0;
    logic          m_terr = 1'b0;
    logic          m_bad = 1'b0;
    int            age = -1;
    int            nb = 0;

    always @(posedge clk or negedge rst_n) begin : model
        bit rdy;
        bit go;
        int lane;
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                mq[i].delete();
                m_inst[i] = '0;
            end
            m_start = '0;
            m_cnt   = '0;
            m_terr  = 1'b0;
            m_bad   = 1'b0;
            age     = -1;
            nb      = 0;
        end else begin
            lane = int'(bus.in_lane);
            rdy  = (lane == 0) || (mq[lane-1].size() < DEPTH);
            go   = (age < 0) && bus.enable && (mq[0].size() + mq[1].size() + mq[2].size() > 0);
            if (age == 0) begin
                age = 1;
            end else if (age > 0) begin
                if (bus.done) begin
                    m_cnt = m_cnt + 16'(nb);
                    age   = -1;
                end else if (age == TIMEOUT) begin
                    m_terr = 1'b1;
                    age    = -1;
                end else begin
                    age++;
                end
            end
            m_start = '0;
            if (go) begin
                nb = 0;
                for (int i = 0; i < 3; i++) begin
                    if (mq[i].size() > 0) begin
                        m_inst[i]  = mq[i].pop_front();
                        m_start[i] = 1'b1;
                        nb++;
                    end
                end
                age = 0;
            end
            if (bus.in_valid && rdy) begin
                if (lane == 0) m_bad = 1'b1;
                else mq[lane-1].push_back(bus.in_instr);
            end
        end
    end

    always @(negedge clk) begin : compare
        int lane;
        if (rst_n) begin
            lane = int'(bus.in_lane);
            check("in_ready", bus.in_ready, (lane == 0) || (mq[lane-1].size() < DEPTH));
            check("inst1", bus.inst1, m_inst[0]);
            check("inst2", bus.inst2, m_inst[1]);
            check("inst3", bus.inst3, m_inst[2]);
            check("starts", {bus.start3, bus.start2, bus.start1}, m_start);
            check("busy", bus.busy, age >= 0);
            check("issued_cnt", bus.issued_cnt, m_cnt);
            check("timeout_err", bus.timeout_err, m_terr);
            check("bad_lane", bus.bad_lane, m_bad);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] lane, input logic [IW-1:0] w);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_lane  = lane;
        bus.in_instr = w;
        for (int n = 0; n < 50 && !ok; n++) begin
            #1;
            ok = bus.in_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) check("push_timeout", 0, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_start();
        for (int n = 0; n < 40; n++) begin
            if (bus.start1 || bus.start2 || bus.start3) return;
            tick();
        end
        check("wait_start_timeout", 0, 1);
    endtask

    task automatic pulse_done();
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
    endtask

    initial begin
        int n;
        bus.in_valid = 1'b0;
        bus.in_lane  = 2'd1;
        bus.in_instr = '0;
        bus.enable   = 1'b0;
        bus.done     = 1'b0;
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_starts", {bus.start3, bus.start2, bus.start1}, 0);
        check("rst_cnt", bus.issued_cnt, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // single lane
        push(2'd2, 28'h0ABCDEF);
        bus.enable = 1'b1;
        wait_start();
        check("s1_inst2", bus.inst2, 28'h0ABCDEF);
        check("s1_start13", {bus.start3, bus.start1}, 0);
        tick();
        check("s1_start2_width", bus.start2, 0);
        tick();
        pulse_done();
        check("s1_cnt", bus.issued_cnt, 1);
        check("s1_busy_fall", bus.busy, 0);
        bus.enable = 1'b0;

        // full bundle
        push(2'd1, 28'h1);
        push(2'd2, 28'h2);
        push(2'd3, 28'h3);
        bus.enable = 1'b1;
        wait_start();
        check("s2_starts", {bus.start3, bus.start2, bus.start1}, 3'b111);
        check("s2_inst1", bus.inst1, 1);
        check("s2_inst2", bus.inst2, 2);
        check("s2_inst3", bus.inst3, 3);
        tick();
        pulse_done();
        check("s2_cnt", bus.issued_cnt, 4);
        bus.enable = 1'b0;

        // FIFO full and order
        for (int i = 0; i < 4; i++) push(2'd1, IW'(11 + i));
        bus.in_valid = 1'b1;
        bus.in_lane  = 2'd1;
        bus.in_instr = IW'(15);
        #1;
        check("s3_full_ready", bus.in_ready, 0);
        tick();
        check("s3_still_full", bus.in_ready, 0);
        bus.enable = 1'b1;
        tick();
        check("s3_first_pop", bus.inst1, 11);
        #1;
        check("s3_ready_after_pop", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        pulse_done();
        for (int k = 1; k < 5; k++) begin
            wait_start();
            check("s3_order", bus.inst1, IW'(11 + k));
            tick();
            pulse_done();
        end
        check("s3_cnt", bus.issued_cnt, 9);
        bus.enable = 1'b0;

        // timeout
        push(2'd3, 28'h33);
        push(2'd3, 28'h34);
        bus.enable = 1'b1;
        wait_start();
        check("s4_inst3", bus.inst3, 28'h33);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            n++;
            if (!bus.busy) break;
        end
        check("s4_busy_cycles", n, 1 + TIMEOUT);
        check("s4_terr", bus.timeout_err, 1);
        check("s4_cnt", bus.issued_cnt, 9);
        wait_start();
        check("s4_next", bus.inst3, 28'h34);
        tick();
        pulse_done();
        check("s4_cnt_after", bus.issued_cnt, 10);
        bus.enable = 1'b0;

        // illegal lane and stray done
        bus.in_valid = 1'b1;
        bus.in_lane  = 2'd0;
        bus.in_instr = 28'hBAD;
        #1;
        check("s5_ready", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        bus.in_lane  = 2'd1;
        check("s5_bad", bus.bad_lane, 1);
        pulse_done();
        check("s5_cnt", bus.issued_cnt, 10);
        check("s5_busy", bus.busy, 0);

        // reset mid-bundle
        push(2'd1, 28'hA1);
        push(2'd1, 28'hA2);
        push(2'd2, 28'hB1);
        bus.enable = 1'b1;
        wait_start();
        bus.enable = 1'b0;
        tick();
        check("s6_in_wait", bus.busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("s6_busy", bus.busy, 0);
        check("s6_inst1", bus.inst1, 0);
        check("s6_inst2", bus.inst2, 0);
        check("s6_cnt", bus.issued_cnt, 0);
        check("s6_flags", {bus.timeout_err, bus.bad_lane}, 0);
        tick();
        tick();
        rst_n = 1'b1;
        bus.enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("s6_no_start", {bus.start3, bus.start2, bus.start1}, 0);
        end

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_lane  = ($urandom_range(0, 15) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
            bus.in_instr = IW'($urandom);
            bus.enable   = ($urandom_range(0, 9) != 0);
            bus.done     = ($urandom_range(0, 3) == 0);
            tick();
        end
        bus.in_valid = 1'b0;
        bus.done     = 1'b0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/instr_dispatch.md
Name: instr_dispatch

Overview:
- Upstream issue stage for the three-lane core.
- Buffers tagged 28-bit instructions in one FIFO per lane.
- Pops up to one instruction per lane into a bundle and drives the core's inst1..3 / start1..3 inputs.
- Holds off the next bundle until the core pulses done. A timeout counter flags a hung core.

Parameters:
- DEPTH, 4: entries per lane FIFO; power of two, at least 2.
- TIMEOUT, 255: maximum WAIT cycles before abandoning a bundle; at least 1.
- IW, 28: instruction width; must match the core's inst ports.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  dispatcher can accept in_instr.
- in_instr  in  IW  instruction word.
- in_lane  in  2  target lane: 1, 2 or 3. Value 0 is illegal.
- enable  in  1  permits bundle issue; does not affect FIFO pushes.
- done  in  1  core completion pulse.
- inst1, inst2, inst3  out  IW  instruction to core lane 1..3.
- start1, start2, start3  out  1  one-cycle start strobe per lane.
- busy  out  1  high in ISSUE or WAIT.
- issued_cnt  out  16  total instructions completed.
- timeout_err  out  1  sticky: a bundle timed out.
- bad_lane  out  1  sticky: a push arrived with in_lane = 0.

Behaviour:
- Reset (async assert, sync release):
  - FIFOs empty; FSM in IDLE.
  - inst1..3 = 0; start1..3 = 0; busy = 0.
  - issued_cnt = 0; timeout_err = 0; bad_lane = 0; timeout counter = 0.
- Input handshake:
  - Transfer occurs when in_valid & in_ready at a rising edge.
  - in_ready = !full of the lane selected by in_lane (combinational).
  - For in_lane = 0, in_ready = 1; the word is dropped and bad_lane sets.
  - No bypass: a word pushed at edge E is issuable at edge E+1 at the earliest.
  - Push and pop on the same lane in the same cycle are both honoured; count is unchanged.
  - A full lane deasserts in_ready even if it is popped that cycle.
- FSM IDLE -> ISSUE:
  - Transition at an edge where enable = 1 and any lane FIFO is non-empty.
  - At that edge, every non-empty lane k pops its head into instk and sets startk = 1.
  - Empty lanes keep their previous instk and get startk = 0.
  - Pop order within a lane is FIFO.
- ISSUE -> WAIT: unconditional after one cycle. start1..3 clear at this edge, so each start is exactly one cycle wide.
- WAIT -> IDLE:
  - On the edge where done = 1, issued_cnt += (start1 + start2 + start3) of the bundle, using a latched mask.
  - issued_cnt wraps modulo 2^16.
  - The timeout counter resets to 0.
- WAIT timeout:
  - The counter increments each WAIT cycle without done.
  - When it reaches TIMEOUT: go to IDLE, set timeout_err, leave issued_cnt unchanged, discard the bundle.
  - If done arrives on the timeout cycle, done wins: completion, no error.
- done in IDLE or ISSUE is ignored.
- inst1..3 hold their values from issue until the next issue overwrites the lane; they are not cleared on done.
- busy = (state != IDLE), registered with the state.
- enable deasserted during ISSUE/WAIT does not abort the bundle. It only blocks the next IDLE -> ISSUE.
- Earliest back-to-back issue: the edge after the WAIT -> IDLE edge. Minimum bundle period is 3 cycles plus done latency.
- Reset asserted mid-bundle: all state clears immediately (async); queued instructions are lost; sticky flags clear.
- Sticky flags clear only on reset.

Test Plan:
- Single lane:
  - Stimulus: reset, push 28'h0ABCDEF to lane 2, enable = 1, done two cycles after start2.
  - Required response: inst2 = 28'h0ABCDEF; start2 high exactly one cycle; start1 = start3 = 0; issued_cnt = 1; busy falls the cycle after done.
- Full bundle:
  - Stimulus: push 28'h1, 28'h2, 28'h3 to lanes 1, 2, 3; then done.
  - Required response: all three starts in the same cycle with inst1 = 1, inst2 = 2, inst3 = 3; issued_cnt = 3.
- FIFO full/order:
  - Stimulus: enable = 0, push 5 words to lane 1 with DEPTH = 4.
  - Required response: in_ready low after 4 pushes; the 5th is stalled. Then enable = 1 with done each bundle: lane 1 issues words 1..4 in order over 4 bundles; the 5th is accepted after the first pop.
- Timeout:
  - Stimulus: TIMEOUT = 8; issue one instruction; never assert done.
  - Required response: the FSM returns to IDLE 8 WAIT cycles later; timeout_err = 1; issued_cnt = 0; the next queued instruction issues afterwards.
- Illegal lane and stray done:
  - Stimulus: push with in_lane = 0; pulse done while IDLE.
  - Required response: in_ready = 1; bad_lane = 1; no FIFO changes; no start; issued_cnt unchanged.
- Reset mid-operation:
  - Stimulus: with 2 entries queued and the FSM in WAIT, drop rst_n asynchronously between edges.
  - Required response: all outputs reach their reset values without waiting for a clock edge; after release, no start fires until new pushes.
